// File: rtl/beat_scheduler_if.sv
// Game-sequencer bus: control inputs from buttons/collision, game status outputs.
interface beat_scheduler_if;
    logic       start;
    logic       pause;
    logic       correct_hit;
    logic       incorrect_hit;
    logic       arrow_valid;
    logic [1:0] game_state;
    logic       beat;
    logic       advance;
    logic       window_open;
    logic       miss;
    logic [3:0] level;
    logic [1:0] lives;

    // Stimulus / consumer side
    modport master (
        output start, pause, correct_hit, incorrect_hit, arrow_valid,
        input  game_state, beat, advance, window_open, miss, level, lives
    );

    // Sequencer side
    modport slave (
        input  start, pause, correct_hit, incorrect_hit, arrow_valid,
        output game_state, beat, advance, window_open, miss, level, lives
    );
endinterface

// File: rtl/beat_scheduler.sv
// Tempo-scaled beat generator, hit-window timer and IDLE/RUN/PAUSE/OVER game sequencer.
module beat_scheduler #(
    parameter int unsigned BASE_PERIOD     = 50000000,
    parameter int unsigned MIN_PERIOD      = 12500000,
    parameter int unsigned PERIOD_STEP     = 2500000,
    parameter int unsigned WINDOW          = 10000000,
    parameter int unsigned COMBO_PER_LEVEL = 8,
    parameter int unsigned LIVES           = 3
) (
    input  logic              clk,
    input  logic              reset,
    beat_scheduler_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int unsigned CNT_W    = 27;
    localparam int unsigned WIN_W    = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int unsigned COMBO_W  = (COMBO_PER_LEVEL > 2) ? $clog2(COMBO_PER_LEVEL) : 1;
    localparam int unsigned MAX_DROP = BASE_PERIOD - MIN_PERIOD;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_q, period_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic               win_open_q, win_open_d;
    logic               win_pend_q, win_pend_d;
    logic               hit_taken_q, hit_taken_d;
    logic               beat_q, beat_d;
    logic               advance_q, advance_d;
    logic               miss_q, miss_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [3:0]         level_q, level_d;
    logic [1:0]         lives_q, lives_d;
    logic [31:0]        drop;
    logic               hit_ok;

    // Next-state, counters, window and scoring
    always_comb begin
        // Clamp on the drop amount so the subtraction can never underflow
        drop        = 32'(level_q) * PERIOD_STEP;
        period_d    = (drop >= MAX_DROP) ? CNT_W'(MIN_PERIOD) : CNT_W'(BASE_PERIOD - drop);
        hit_ok      = win_open_q && !hit_taken_q && (bus.correct_hit || bus.incorrect_hit);
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_cnt_d   = win_cnt_q;
        win_open_d  = win_open_q;
        win_pend_d  = win_pend_q;
        hit_taken_d = hit_taken_q;
        beat_d      = 1'b0;
        advance_d   = 1'b0;
        miss_d      = 1'b0;
        combo_d     = combo_q;
        level_d     = level_q;
        lives_d     = lives_q;

        if (bus.start && state_q != ST_PAUSE) begin
            // Game (re)start: fresh level-0 beat from now
            state_d     = ST_RUN;
            cnt_d       = CNT_W'(BASE_PERIOD - 1);
            win_open_d  = 1'b0;
            win_pend_d  = 1'b0;
            hit_taken_d = 1'b0;
            combo_d     = '0;
            level_d     = '0;
            lives_d     = 2'(LIVES);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cnt_q == '0) begin
                        beat_d = 1'b1;
                        cnt_d  = period_q - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (lives_q == '0) begin
                        state_d    = ST_OVER;
                        win_open_d = 1'b0;
                        win_pend_d = 1'b0;
                    end else begin
                        if (bus.pause) state_d = ST_PAUSE;
                        if (cnt_q == '0) begin
                            beat_d     = 1'b1;
                            advance_d  = 1'b1;
                            win_pend_d = 1'b1;
                            cnt_d      = period_q - CNT_W'(1);
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                        // Pending flag survives a pause landing right after advance
                        if (win_pend_q) begin
                            win_pend_d  = 1'b0;
                            win_open_d  = 1'b1;
                            win_cnt_d   = WIN_W'(WINDOW - 1);
                            hit_taken_d = 1'b0;
                        end else if (win_open_q) begin
                            if (hit_ok) begin
                                hit_taken_d = 1'b1;
                                if (bus.incorrect_hit) begin
                                    combo_d = '0;
                                    lives_d = lives_q - 2'd1;
                                end else if (combo_q == COMBO_W'(COMBO_PER_LEVEL - 1)) begin
                                    combo_d = '0;
                                    if (level_q != 4'hF) level_d = level_q + 4'd1;
                                end else begin
                                    combo_d = combo_q + COMBO_W'(1);
                                end
                            end
                            if (win_cnt_q == '0) begin
                                win_open_d = 1'b0;
                                // A hit on the last open cycle still counts
                                if (bus.arrow_valid && !hit_taken_q && !hit_ok) begin
                                    miss_d  = 1'b1;
                                    combo_d = '0;
                                    lives_d = lives_q - 2'd1;
                                end
                            end else begin
                                win_cnt_d = win_cnt_q - WIN_W'(1);
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!bus.pause) state_d = ST_RUN;
                end
                ST_OVER: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= CNT_W'(BASE_PERIOD - 1);
            period_q    <= CNT_W'(BASE_PERIOD);
            win_cnt_q   <= '0;
            win_open_q  <= 1'b0;
            win_pend_q  <= 1'b0;
            hit_taken_q <= 1'b0;
            beat_q      <= 1'b0;
            advance_q   <= 1'b0;
            miss_q      <= 1'b0;
            combo_q     <= '0;
            level_q     <= '0;
            lives_q     <= 2'(LIVES);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            win_cnt_q   <= win_cnt_d;
            win_open_q  <= win_open_d;
            win_pend_q  <= win_pend_d;
            hit_taken_q <= hit_taken_d;
            beat_q      <= beat_d;
            advance_q   <= advance_d;
            miss_q      <= miss_d;
            combo_q     <= combo_d;
            level_q     <= level_d;
            lives_q     <= lives_d;
        end
    end

    assign bus.game_state  = state_q;
    assign bus.beat        = beat_q;
    assign bus.advance     = advance_q;
    assign bus.window_open = win_open_q;
    assign bus.miss        = miss_q;
    assign bus.level       = level_q;
    assign bus.lives       = lives_q;

endmodule
